// File: rtl/robo_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// robo_ctrl_pkg : shared state encoding, default timing and orientation codes
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package robo_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_CONT = 2'd1,
    S_STEP = 2'd2,
    S_HALT = 2'd3
  } estado_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_RUN_DIV         = 8;
  localparam int DEF_RESET_HOLD      = 2;

  // Orientation codes shared with the robot datapath.
  typedef enum logic [1:0] {
    N = 2'd0,
    S = 2'd1,
    L = 2'd2,
    O = 2'd3
  } orientacao_t;

endpackage

`default_nettype wire

// File: rtl/controle_execucao_debounce.sv
// ---------------------------------------------------------------------------
// debounce_botao : 2-FF synchronizer + stability counter, rising-edge press pulse
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module debounce_botao
  import robo_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync1;
  logic       sync2;
  logic [7:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= 8'd0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= 8'd0;
          press <= sync2;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end else begin
        cnt <= 8'd0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/controle_execucao.sv
// ---------------------------------------------------------------------------
// controle_execucao : robot execution controller (reset/enable sequencing,
// continuous/step modes, anomaly halt). Optional macro CONTROLE_STEP_COUNT_EN
// adds the saturating enable counter output passos.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module controle_execucao
  import robo_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int RUN_DIV         = DEF_RUN_DIV,
  parameter int RESET_HOLD      = DEF_RESET_HOLD
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_reset_raw,
  input  logic        btn_mode_raw,
  input  logic        btn_step_raw,
  input  logic        anomalia,
  output logic        robo_reset,
  output logic        robo_enable,
  output logic        step_mode,
  output logic        halted,
  output logic [1:0]  estado
`ifdef CONTROLE_STEP_COUNT_EN
  ,
  output logic [15:0] passos
`endif
);

  localparam logic [15:0] DIV_LAST  = 16'(RUN_DIV - 1);
  localparam logic [3:0]  HOLD_LAST = 4'(RESET_HOLD - 1);

  logic [2:0] levels_unused;
  logic       reset_press;
  logic       mode_press;
  logic       step_press;

  debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_reset (
    .clock(clock), .reset(reset), .raw(btn_reset_raw),
    .level(levels_unused[0]), .press(reset_press)
  );

  debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
    .clock(clock), .reset(reset), .raw(btn_mode_raw),
    .level(levels_unused[1]), .press(mode_press)
  );

  debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_step (
    .clock(clock), .reset(reset), .raw(btn_step_raw),
    .level(levels_unused[2]), .press(step_press)
  );

  estado_t     state;
  estado_t     state_n;
  logic [15:0] div_cnt;
  logic [15:0] div_n;
  logic [3:0]  hold_cnt;
  logic [3:0]  hold_n;
  logic        step_mode_n;
  logic        halted_n;
  logic        robo_reset_n;
  logic        enable_n;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_RST;
      div_cnt     <= 16'd0;
      hold_cnt    <= 4'd0;
      step_mode   <= 1'b0;
      halted      <= 1'b0;
      robo_reset  <= 1'b1;
      robo_enable <= 1'b0;
    end else begin
      state       <= state_n;
      div_cnt     <= div_n;
      hold_cnt    <= hold_n;
      step_mode   <= step_mode_n;
      halted      <= halted_n;
      robo_reset  <= robo_reset_n;
      robo_enable <= enable_n;
    end
  end

  // Operator reset pre-empts everything; otherwise each state resolves its own
  // priority of anomaly > mode > tick/step.
  always_comb begin
    state_n      = state;
    div_n        = div_cnt;
    hold_n       = hold_cnt;
    step_mode_n  = step_mode;
    halted_n     = halted;
    robo_reset_n = 1'b0;
    enable_n     = 1'b0;
    if (reset_press) begin
      state_n      = S_RST;
      div_n        = 16'd0;
      hold_n       = 4'd0;
      halted_n     = 1'b0;
      robo_reset_n = 1'b1;
    end else begin
      case (state)
        S_RST: begin
          div_n = 16'd0;
          if (mode_press) step_mode_n = ~step_mode;
          if (hold_cnt == HOLD_LAST) begin
            hold_n  = 4'd0;
            state_n = step_mode_n ? S_STEP : S_CONT;
          end else begin
            hold_n       = hold_cnt + 4'd1;
            robo_reset_n = 1'b1;
          end
        end
        S_CONT: begin
          if (anomalia) begin
            state_n  = S_HALT;
            halted_n = 1'b1;
          end else if (mode_press) begin
            step_mode_n = 1'b1;
            state_n     = S_STEP;
            div_n       = 16'd0;
          end else if (div_cnt == DIV_LAST) begin
            div_n    = 16'd0;
            enable_n = 1'b1;
          end else begin
            div_n = div_cnt + 16'd1;
          end
        end
        S_STEP: begin
          if (anomalia) begin
            state_n  = S_HALT;
            halted_n = 1'b1;
          end else if (mode_press) begin
            step_mode_n = 1'b0;
            state_n     = S_CONT;
            div_n       = 16'd0;
          end else if (step_press) begin
            enable_n = 1'b1;
          end
        end
        S_HALT: begin
          if (mode_press) step_mode_n = ~step_mode;
        end
        default: state_n = S_RST;
      endcase
    end
  end

  assign estado = state;

`ifdef CONTROLE_STEP_COUNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      passos <= 16'd0;
    end else if (state == S_RST) begin
      passos <= 16'd0;
    end else if (enable_n && (passos != 16'hFFFF)) begin
      passos <= passos + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire
